pgm_tx_render: RTL and testbench

Text-layer (TX) scanline renderer. It sits downstream of the 68k video RAM at 904000 and upstream of the palette lookup and mixer. For each upcoming line it fetches tile entries from video RAM and 8-pixel tile rows from graphics ROM, and fills a double-buffered line buffer. During the displayed line it streams palette indices per pixel.

---
 rtl/pgm_video_pkg.sv | 34 +++
 rtl/pgm_tx_render_if.sv | 30 +++
 rtl/pgm_line_buffer.sv | 50 +++++
 rtl/pgm_tx_render.sv | 205 ++++++++++++++++++++
 tb/tb_pgm_tx_render.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pgm_video_pkg.sv
// Shared definitions for the PGM video pipeline, text-layer part.
// Provides TX tilemap geometry, attribute bit positions, the packed
// palette+pen pixel type stored in the line buffer, and the fetch FSM
// state enum.
package pgm_video_pkg;

    localparam int TX_H_VISIBLE       = 448;
    localparam int TX_TILES_PER_LINE  = 57;
    localparam logic [3:0] TX_TRANSPARENT_PEN = 4'hF;

    localparam int TX_MAP_W_TILES     = 64;
    localparam int TX_MAP_H_TILES     = 32;
    localparam int TX_TILE_PX         = 8;
    localparam int TX_LB_DEPTH        = TX_MAP_W_TILES * TX_TILE_PX;   // 512 per bank

    localparam int TX_ATTR_PAL_LSB    = 1;
    localparam int TX_ATTR_PAL_MSB    = 5;
    localparam int TX_ATTR_FLIPX      = 6;
    localparam int TX_ATTR_FLIPY      = 7;

    typedef struct packed {
        logic [4:0] palette;
        logic [3:0] pen;
    } tx_pixel_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_CODE  = 3'd1,
        TX_ATTR  = 3'd2,
        TX_ROM   = 3'd3,
        TX_WRITE = 3'd4
    } tx_state_t;

endpackage

// File: rtl/pgm_tx_render_if.sv
// Memory-side bus of the text renderer: video RAM read port and
// graphics ROM request/acknowledge port.
//   master : the renderer (drives addresses and rom_req)
//   slave  : the memory subsystem (returns vram_din, rom_ack, rom_data)
interface pgm_tx_render_if;
    logic [11:0] vram_addr;
    logic [15:0] vram_din;
    logic        rom_req;
    logic [18:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;

    modport master (
        output vram_addr,
        input  vram_din,
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  vram_addr,
        output vram_din,
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data
    );
endinterface

// File: rtl/pgm_line_buffer.sv
// Double-banked text line buffer, 2 x 512 entries of tx_pixel_t.
// The fetch side writes the back bank, the display side reads the front
// bank. bank_sel names the front bank and toggles on swap.
// Ports:
//   clk, rst            clock, async active-high reset
//   swap                toggle front/back
//   wr_en/wr_addr/wr_data  back-bank write port
//   rd_en/rd_addr       front-bank read, registered into rd_data
//   bank_sel            current front bank
module pgm_line_buffer
    import pgm_video_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      swap,
    input  logic      wr_en,
    input  logic [8:0] wr_addr,
    input  tx_pixel_t wr_data,
    input  logic      rd_en,
    input  logic [8:0] rd_addr,
    output tx_pixel_t rd_data,
    output logic      bank_sel
);

    // {bank, x} addressing; contents are not reset.
    tx_pixel_t mem [0:2*TX_LB_DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel <= 1'b0;
        end else if (swap) begin
            bank_sel <= ~bank_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~bank_sel, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{bank_sel, rd_addr}];
        end
    end

endmodule

// File: rtl/pgm_tx_render.sv
// Text-layer scanline renderer. On line_start it swaps line-buffer banks,
// latches the line and scrolls, then fetches TILES_PER_LINE tile entries
// from video RAM and their 8-pixel rows from graphics ROM, writing the
// visible pixels into the back bank. The display side streams the front
// bank by pix_x with one pixel-enable of latency.
// Ports:
//   fixed_20m_clk, reset        clock, async active-high reset
//   line_start, line_y          start fetching a line (also swaps banks)
//   tx_xscroll, tx_yscroll      scroll registers ([8:0] / [7:0] used)
//   mem                         VRAM + ROM bus (master side)
//   pix_ce, pix_x               display read strobe and x position
//   pix_out, pix_opaque         {palette, pen} and opacity of pixel
//   busy, overrun               fetch active; sticky late-line flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// TX_IDLE  | no fetch pending; line done or never started
// TX_CODE  | 2 cycles: drive code address, capture vram_din on 2nd
// TX_ATTR  | 2 cycles: drive attribute address, capture on 2nd
// TX_ROM   | rom_req held with stable address until rom_ack
// TX_WRITE | 8 cycles: one pixel of the tile row per cycle
module pgm_tx_render
    import pgm_video_pkg::*;
#(
    parameter int         H_VISIBLE       = TX_H_VISIBLE,
    parameter int         TILES_PER_LINE  = TX_TILES_PER_LINE,
    parameter logic [3:0] TRANSPARENT_PEN = TX_TRANSPARENT_PEN
) (
    input  logic         fixed_20m_clk,
    input  logic         reset,
    input  logic         line_start,
    input  logic [7:0]   line_y,
    input  logic [15:0]  tx_xscroll,
    input  logic [15:0]  tx_yscroll,
    pgm_tx_render_if.master mem,
    input  logic         pix_ce,
    input  logic [8:0]   pix_x,
    output logic [8:0]   pix_out,
    output logic         pix_opaque,
    output logic         busy,
    output logic         overrun
);

    tx_state_t state, state_nx;

    logic        ph;
    logic [7:0]  line_y_q;
    logic [7:0]  yscroll_q;
    logic [2:0]  fine_q;
    logic [5:0]  col;
    logic [5:0]  tile_i;
    logic [2:0]  px;
    logic [15:0] code_q;
    logic [7:1]  attr_q;
    logic [31:0] row_pix_q;

    logic [7:0]  ty;
    logic [2:0]  rom_row;
    logic        last_tile;
    logic signed [9:0] sx;
    logic [2:0]  nib;
    logic        wr_en;
    tx_pixel_t   wr_data;
    tx_pixel_t   rd_data;
    logic        bank_sel;
    logic        oob_q;
    logic        seen_q;
    logic        scroll_unused;

    assign scroll_unused = ^{tx_xscroll[15:9], tx_yscroll[15:8], bank_sel};

    assign ty        = line_y_q + yscroll_q;
    assign rom_row   = attr_q[TX_ATTR_FLIPY] ? ~ty[2:0] : ty[2:0];
    assign last_tile = (tile_i == 6'(TILES_PER_LINE - 1));

    // Screen x of the pixel being written; negative for the fine-scroll
    // pixels of the first tile, past the edge for the tail of the last.
    assign sx  = $signed({1'b0, tile_i, px}) - $signed({7'd0, fine_q});
    assign nib = attr_q[TX_ATTR_FLIPX] ? ~px : px;

    always_comb begin
        wr_data.palette = attr_q[TX_ATTR_PAL_MSB:TX_ATTR_PAL_LSB];
        wr_data.pen     = row_pix_q[{nib, 2'b00} +: 4];
        wr_en = (state == TX_WRITE) && !line_start &&
                (sx >= 10'sd0) && (sx < $signed(10'(H_VISIBLE)));
    end

    // State register
    always_ff @(posedge fixed_20m_clk or posedge reset) begin
        if (reset) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; line_start overrides everything, including a wait on ROM.
    always_comb begin
        state_nx = state;
        if (line_start) begin
            state_nx = TX_CODE;
        end else begin
            case (state)
                TX_IDLE:  state_nx = TX_IDLE;
                TX_CODE:  if (ph) state_nx = TX_ATTR;
                TX_ATTR:  if (ph) state_nx = TX_ROM;
                TX_ROM:   if (mem.rom_ack) state_nx = TX_WRITE;
                TX_WRITE: if (px == 3'd7) state_nx = last_tile ? TX_IDLE : TX_CODE;
                default:  state_nx = TX_IDLE;
            endcase
        end
    end

    // Outputs decoded from state only, so rom_req falls the cycle after
    // the ack or an abort.
    always_comb begin
        busy          = (state != TX_IDLE);
        mem.vram_addr = '0;
        mem.rom_req   = 1'b0;
        mem.rom_addr  = '0;
        case (state)
            TX_CODE: mem.vram_addr = {ty[7:3], col, 1'b0};
            TX_ATTR: mem.vram_addr = {ty[7:3], col, 1'b1};
            TX_ROM: begin
                mem.rom_req  = 1'b1;
                mem.rom_addr = {code_q, rom_row};
            end
            default: ;
        endcase
    end

    // Fetch datapath
    always_ff @(posedge fixed_20m_clk or posedge reset) begin
        if (reset) begin
            ph        <= 1'b0;
            line_y_q  <= '0;
            yscroll_q <= '0;
            fine_q    <= '0;
            col       <= '0;
            tile_i    <= '0;
            px        <= '0;
            code_q    <= '0;
            attr_q    <= '0;
            row_pix_q <= '0;
            overrun   <= 1'b0;
        end else if (line_start) begin
            ph        <= 1'b0;
            line_y_q  <= line_y;
            yscroll_q <= tx_yscroll[7:0];
            fine_q    <= tx_xscroll[2:0];
            col       <= tx_xscroll[8:3];
            tile_i    <= '0;
            px        <= '0;
            if (busy) begin
                overrun <= 1'b1;
            end
        end else begin
            ph <= ((state == TX_CODE) || (state == TX_ATTR)) ? ~ph : 1'b0;
            case (state)
                TX_CODE: if (ph) code_q <= mem.vram_din;
                TX_ATTR: if (ph) attr_q <= mem.vram_din[7:1];
                TX_ROM:  if (mem.rom_ack) row_pix_q <= mem.rom_data;
                TX_WRITE: begin
                    px <= px + 3'd1;
                    if (px == 3'd7) begin
                        tile_i <= tile_i + 6'd1;
                        col    <= col + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    pgm_line_buffer u_lbuf (
        .clk      (fixed_20m_clk),
        .rst      (reset),
        .swap     (line_start),
        .wr_en    (wr_en),
        .wr_addr  (sx[8:0]),
        .wr_data  (wr_data),
        .rd_en    (pix_ce),
        .rd_addr  (pix_x),
        .rd_data  (rd_data),
        .bank_sel (bank_sel)
    );

    // Display side: the buffer read is registered; out-of-range and
    // "nothing read yet" are tracked alongside so outputs start at 0.
    always_ff @(posedge fixed_20m_clk or posedge reset) begin
        if (reset) begin
            oob_q  <= 1'b0;
            seen_q <= 1'b0;
        end else if (pix_ce) begin
            oob_q  <= (pix_x >= 9'(H_VISIBLE));
            seen_q <= 1'b1;
        end
    end

    always_comb begin
        pix_out    = oob_q ? {5'd0, TRANSPARENT_PEN} : rd_data;
        pix_opaque = seen_q && !oob_q && (rd_data.pen != TRANSPARENT_PEN);
    end

endmodule

// File: tb/tb_pgm_tx_render.sv
module tb_pgm_tx_render;
    import pgm_video_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [7:0]  line_y = '0;
    logic [15:0] tx_xscroll = '0;
    logic [15:0] tx_yscroll = '0;
    logic        pix_ce = 1'b0;
    logic [8:0]  pix_x = '0;
    logic [8:0]  pix_out;
    logic        pix_opaque;
    logic        busy;
    logic        overrun;

    pgm_tx_render_if bus();

    pgm_tx_render dut (
        .fixed_20m_clk (clk),
        .reset         (reset),
        .line_start    (line_start),
        .line_y        (line_y),
        .tx_xscroll    (tx_xscroll),
        .tx_yscroll    (tx_yscroll),
        .mem           (bus),
        .pix_ce        (pix_ce),
        .pix_x         (pix_x),
        .pix_out       (pix_out),
        .pix_opaque    (pix_opaque),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #25 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] vram [0:4095];
    logic [31:0] salt = 32'h1234_5678;
    bit          rom_all_f = 1'b0;
    bit          lat_rand = 1'b1;
    int          rom_lat = 0;
    bit          inject = 1'b0;
    int          ack_count = 0;
    logic [18:0] first_rom_addr = '0;
    logic [18:0] line_rom_addr0 = '0;

    function automatic logic [31:0] rom_fn(input logic [18:0] a);
        if (rom_all_f) return 32'hFFFF_FFFF;
        if (a == {16'h0001, 3'd0}) return 32'h7654_3210;
        return ({13'd0, a} * 32'h9E37_79B1) ^ salt;
    endfunction

    // Reference: map each screen pixel straight into the 512x256 tilemap.
    function automatic logic [9:0] model_pix(input int sx, input int ly, input int xs, input int ys);
        int ty, xm, colm, rowm, pxm, r, idx;
        logic [15:0] code, attr;
        logic [31:0] w;
        logic [3:0] pen;
        if (sx >= 448) return {1'b0, 5'd0, 4'hF};
        ty   = (ly + ys) % 256;
        xm   = (sx + xs) % 512;
        colm = xm / 8;
        pxm  = xm % 8;
        rowm = ty / 8;
        r    = ty % 8;
        code = vram[rowm * 128 + colm * 2];
        attr = vram[rowm * 128 + colm * 2 + 1];
        if (attr[7]) r = 7 - r;
        idx  = attr[6] ? 7 - pxm : pxm;
        w    = rom_fn({code, 3'(r)});
        pen  = w[idx * 4 +: 4];
        return {pen != 4'hF, attr[5:1], pen};
    endfunction

    // VRAM: data for the address seen in the previous cycle.
    initial begin
        logic [11:0] a_prev;
        a_prev = '0;
        bus.vram_din = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.vram_din = vram[a_prev];
            a_prev = bus.vram_addr;
        end
    end

    // ROM responder with configurable latency and a stray-ack injector.
    initial begin
        int cnt, want;
        cnt = 0;
        want = 0;
        bus.rom_ack = 1'b0;
        bus.rom_data = '0;
        forever begin
            @(negedge clk);
            bus.rom_ack = 1'b0;
            if (inject) begin
                bus.rom_ack = 1'b1;
                bus.rom_data = 32'hDEAD_BEEF;
                inject = 1'b0;
                cnt = 0;
            end else if (bus.rom_req) begin
                if (cnt >= want) begin
                    bus.rom_ack = 1'b1;
                    bus.rom_data = rom_fn(bus.rom_addr);
                    if (ack_count == 0) first_rom_addr = bus.rom_addr;
                    ack_count++;
                    cnt = 0;
                    want = lat_rand ? int'($urandom_range(0, 6)) : rom_lat;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                want = lat_rand ? int'($urandom_range(0, 6)) : rom_lat;
            end
        end
    end

    initial begin
        #4500000;
        $display("FAIL watchdog expired observed running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic pulse(input logic [7:0] ly, input logic [15:0] xs, input logic [15:0] ys);
        logic [7:0] ty;
        @(negedge clk);
        line_y = ly;
        tx_xscroll = xs;
        tx_yscroll = ys;
        ack_count = 0;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        ty = ly + ys[7:0];
        check("first_vram_addr", bus.vram_addr, {ty[7:3], xs[8:3], 1'b0});
        check("busy_after_start", busy, 1);
    endtask

    // Fetch a line, then swap it to the front with a different line behind it.
    task automatic render(input logic [7:0] ly, input logic [15:0] xs, input logic [15:0] ys);
        pulse(ly, xs, ys);
        wait_idle("fetch_done");
        check("ack_count", ack_count, 57);
        line_rom_addr0 = first_rom_addr;
        pulse(8'((int'(ly) + 8) % 224), xs ^ 16'h0011, ys);
        wait_idle("swap_done");
    endtask

    task automatic read_pix(input logic [8:0] x, output logic [9:0] v);
        @(negedge clk);
        pix_x = x;
        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
        v = {pix_opaque, pix_out};
    endtask

    task automatic check_line(input int ly, input int xs, input int ys);
        logic [9:0] v;
        for (int sx = 0; sx < 448; sx++) begin
            read_pix(9'(sx), v);
            check($sformatf("pix_%0d", sx), v, model_pix(sx, ly, xs % 512, ys % 256));
        end
    endtask

    initial begin
        logic [9:0] v;
        logic [7:0] ly;
        logic [15:0] xs, ys;
        logic [15:0] c, a;
        int x;

        for (int i = 0; i < 4096; i++) vram[i] = 16'($urandom);
        salt = $urandom;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vram_addr", bus.vram_addr, 0);
        check("rst_rom_req", bus.rom_req, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_pix_out", pix_out, 0);
        check("rst_pix_opaque", pix_opaque, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Plain tile at the origin
        vram[0] = 16'h0001;
        vram[1] = 16'h0002;
        render(8'd0, 16'd0, 16'd0);
        for (int p = 0; p < 8; p++) begin
            read_pix(9'(p), v);
            check("plain_pix", v, {1'b1, 5'd1, 4'(p)});
        end
        read_pix(9'd3, v);
        @(negedge clk);
        pix_x = 9'd5;
        @(posedge clk);
        #1;
        check("hold_no_ce", {pix_opaque, pix_out}, {1'b1, 5'd1, 4'd3});
        check_line(0, 0, 0);

        // flipx
        vram[1] = 16'h0042;
        render(8'd0, 16'd0, 16'd0);
        read_pix(9'd0, v);
        check("flipx_pix0", v, {1'b1, 5'd1, 4'd7});
        read_pix(9'd7, v);
        check("flipx_pix7", v, {1'b1, 5'd1, 4'd0});
        check_line(0, 0, 0);

        // flipy
        vram[1] = 16'h0082;
        render(8'd0, 16'd0, 16'd0);
        check("flipy_rom_addr", line_rom_addr0, {16'h0001, 3'd7});
        check_line(0, 0, 0);

        // Fine scroll drops the first pixels of tile 0
        vram[1] = 16'h0002;
        render(8'd0, 16'd3, 16'd0);
        read_pix(9'd0, v);
        check("fine_pix0", v, {1'b1, 5'd1, 4'd3});
        check_line(0, 3, 0);

        // Column wrap 63 -> 0
        render(8'd0, 16'h01F8, 16'd0);
        check_line(0, 'h1F8, 0);

        // Vertical wrap: 8 + 0xFC -> row 0, r 4
        render(8'd8, 16'd0, 16'h00FC);
        check("ywrap_rom_addr", line_rom_addr0, {16'h0001, 3'd4});
        check_line(8, 0, 'hFC);

        // All-transparent ROM
        rom_all_f = 1'b1;
        render(8'd0, 16'd0, 16'd0);
        for (int p = 0; p < 8; p++) begin
            read_pix(9'(p), v);
            check("transp_opaque", v[9], 0);
            check("transp_pen", v[3:0], 4'hF);
        end
        read_pix(9'd450, v);
        check("oob_450", v, {1'b0, 5'd0, 4'hF});
        rom_all_f = 1'b0;

        // Random lines
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4096; i++) vram[i] = 16'($urandom);
            salt = $urandom;
            ly = 8'($urandom_range(0, 223));
            xs = 16'($urandom);
            ys = 16'($urandom);
            render(ly, xs, ys);
            check_line(int'(ly), int'(xs), int'(ys));
            x = $urandom_range(448, 511);
            read_pix(9'(x), v);
            check("oob_rand", v, {1'b0, 5'd0, 4'hF});
        end

        // Late ROM, abort mid-fetch
        check("overrun_clear", overrun, 0);
        lat_rand = 1'b0;
        rom_lat = 200;
        pulse(8'd10, 16'h0040, 16'd0);
        x = 0;
        while (bus.rom_req !== 1'b1 && x < 50) begin
            @(posedge clk);
            #1;
            x++;
        end
        check("rom_req_wait", bus.rom_req, 1);
        repeat (20) @(posedge clk);
        #1;
        check("overrun_before", overrun, 0);
        check("rom_req_held", bus.rom_req, 1);
        pulse(8'd20, 16'h0123, 16'h0005);
        check("overrun_set", overrun, 1);
        check("rom_req_dropped", bus.rom_req, 0);
        rom_lat = 0;
        inject = 1'b1;
        wait_idle("restart_done");
        check("restart_acks", ack_count, 57);
        c = vram[3 * 128 + 36 * 2];
        a = vram[3 * 128 + 36 * 2 + 1];
        check("restart_rom_addr", first_rom_addr, {c, a[7] ? 3'd6 : 3'd1});
        lat_rand = 1'b1;
        pulse(8'd28, 16'h0132, 16'h0005);
        wait_idle("restart_swap");
        check_line(20, 'h123, 5);
        check("overrun_sticky", overrun, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
